// File: rtl/lsu_ctrl.sv
// Load/store sequencer: splits byte/half/word accesses at any alignment into
// one or two byte-masked word transactions and assembles extended load results.
module lsu_ctrl #(
  parameter int ADDR_W = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic              rsp_err,
  output logic [31:0]       rsp_rdata,
  output logic              mem_rden,
  output logic              mem_wren,
  output logic [ADDR_W-3:0] mem_addr,
  output logic [3:0]        mem_wmask,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  // state   | meaning
  // IDLE    | waiting for a request
  // ST_LO   | write low word lanes
  // ST_HI   | write high word lanes (spanning store)
  // LD_LO   | read low word
  // LD_HI   | read high word, capture low word data
  // LD_WAIT | capture last read word, form load result
  // RSP     | one-cycle response
  typedef enum logic [2:0] {IDLE, ST_LO, ST_HI, LD_LO, LD_HI, LD_WAIT, RSP} state_t;

  state_t state, state_nx;

  logic              we_q, uns_q, err_q;
  logic [1:0]        size_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q, lo_q, rdata_q;

  logic              accept;
  logic [1:0]        off;
  logic [3:0]        base_mask;
  logic [7:0]        lane_mask;
  logic [63:0]       lane_data;
  logic              span;
  logic [ADDR_W-3:0] word_lo, word_hi;
  logic [63:0]       rd_shift;
  logic [31:0]       rd_lo, rd_hi, ld_result;

  assign req_ready = rst_n & (state == IDLE);
  assign accept    = req_valid & req_ready;
  assign rsp_err   = (state == RSP) & err_q;
  assign rsp_rdata = rdata_q;

  assign off       = addr_q[1:0];
  assign word_lo   = addr_q[ADDR_W-1:2];
  assign word_hi   = word_lo + 1'b1;
  assign lane_mask = {4'b0000, base_mask} << off;
  assign lane_data = {32'h0, wdata_q} << {off, 3'b000};
  assign span      = |lane_mask[7:4];

  always_comb begin
    base_mask = 4'b1111;
    case (size_q)
      2'd0:    base_mask = 4'b0001;
      2'd1:    base_mask = 4'b0011;
      default: base_mask = 4'b1111;
    endcase
  end

  // In LD_WAIT mem_rdata carries the last word read: high word if spanning.
  always_comb begin
    rd_lo     = span ? lo_q : mem_rdata;
    rd_hi     = span ? mem_rdata : 32'h0;
    rd_shift  = {rd_hi, rd_lo} >> {off, 3'b000};
    ld_result = rd_shift[31:0];
    case (size_q)
      2'd0:    ld_result = {{24{~uns_q & rd_shift[7]}}, rd_shift[7:0]};
      2'd1:    ld_result = {{16{~uns_q & rd_shift[15]}}, rd_shift[15:0]};
      default: ld_result = rd_shift[31:0];
    endcase
  end

  always_comb begin
    state_nx  = state;
    rsp_valid = 1'b0;
    mem_rden  = 1'b0;
    mem_wren  = 1'b0;
    mem_addr  = '0;
    mem_wmask = 4'b0000;
    mem_wdata = 32'h0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (req_size == 2'd3) state_nx = RSP;
          else if (req_we)      state_nx = ST_LO;
          else                  state_nx = LD_LO;
        end
      end
      ST_LO: begin
        mem_wren  = 1'b1;
        mem_addr  = word_lo;
        mem_wmask = lane_mask[3:0];
        mem_wdata = lane_data[31:0];
        state_nx  = span ? ST_HI : RSP;
      end
      ST_HI: begin
        mem_wren  = 1'b1;
        mem_addr  = word_hi;
        mem_wmask = lane_mask[7:4];
        mem_wdata = lane_data[63:32];
        state_nx  = RSP;
      end
      LD_LO: begin
        mem_rden = 1'b1;
        mem_addr = word_lo;
        state_nx = span ? LD_HI : LD_WAIT;
      end
      LD_HI: begin
        mem_rden = 1'b1;
        mem_addr = word_hi;
        state_nx = LD_WAIT;
      end
      LD_WAIT: state_nx = RSP;
      RSP: begin
        rsp_valid = 1'b1;
        state_nx  = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      err_q   <= 1'b0;
      size_q  <= 2'd0;
      addr_q  <= '0;
      wdata_q <= 32'h0;
      lo_q    <= 32'h0;
      rdata_q <= 32'h0;
    end else begin
      state <= state_nx;
      if (accept) begin
        we_q    <= req_we;
        uns_q   <= req_unsigned;
        err_q   <= (req_size == 2'd3);
        size_q  <= req_size;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
      end
      if (state == LD_HI) lo_q <= mem_rdata;
      // Stores and errors respond with zero data; loads with the assembled word.
      if (state_nx == RSP)
        rdata_q <= (state == LD_WAIT && !we_q) ? ld_result : 32'h0;
    end
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed vector bench for lsu_ctrl with a byte-masked word memory model.
module tb_lsu_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'd0;
  logic        req_unsigned = 1'b0;
  logic [6:0]  req_addr = 7'd0;
  logic [31:0] req_wdata = 32'h0;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic        mem_rden, mem_wren;
  logic [4:0]  mem_addr;
  logic [3:0]  mem_wmask;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  int checks = 0;
  int errors = 0;

  lsu_ctrl #(.ADDR_W(7)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_err(rsp_err),
    .rsp_rdata(rsp_rdata), .mem_rden(mem_rden), .mem_wren(mem_wren),
    .mem_addr(mem_addr), .mem_wmask(mem_wmask), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [32];
  logic        mem_clear = 1'b1;

  always @(posedge clk) begin
    if (mem_clear) begin
      for (int i = 0; i < 32; i++) mem[i] <= 32'h0;
      mem_rdata <= 32'h0;
    end else begin
      if (mem_wren)
        for (int b = 0; b < 4; b++)
          if (mem_wmask[b]) mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
      if (mem_rden) mem_rdata <= mem[mem_addr];
    end
  end

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [6:0]  addr;
    logic [31:0] wdata;
    int          lat;
    logic [1:0]  s1;   // {wren, rden} in C1
    logic [4:0]  a1;
    logic [3:0]  m1;
    logic [31:0] w1;
    logic [1:0]  s2;
    logic [4:0]  a2;
    logic [3:0]  m2;
    logic [31:0] w2;
    logic [31:0] rdata;
    logic        err;
  } vec_t;

  vec_t vecs[16];

  function automatic vec_t mk(logic we, logic [1:0] size, logic uns, logic [6:0] addr,
                              logic [31:0] wdata, int lat,
                              logic [1:0] s1, logic [4:0] a1, logic [3:0] m1, logic [31:0] w1,
                              logic [1:0] s2, logic [4:0] a2, logic [3:0] m2, logic [31:0] w2,
                              logic [31:0] rdata, logic err);
    vec_t v;
    v.we = we; v.size = size; v.uns = uns; v.addr = addr; v.wdata = wdata; v.lat = lat;
    v.s1 = s1; v.a1 = a1; v.m1 = m1; v.w1 = w1;
    v.s2 = s2; v.a2 = a2; v.m2 = m2; v.w2 = w2;
    v.rdata = rdata; v.err = err;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%08h expected=%08h", nm, act, exp);
    end
  endtask

  task automatic chk_bus(input string nm);
    chk({nm, "_excl"}, 32'(mem_wren & mem_rden), 32'h0);
    if (!mem_wren && !mem_rden)
      chk({nm, "_idle_bus"}, {27'h0, mem_addr} | {28'h0, mem_wmask} | mem_wdata, 32'h0);
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_ctl"}, {26'h0, req_ready, rsp_valid, rsp_err, mem_rden, mem_wren, 1'b0}, 32'h0);
    chk({nm, "_rdata"}, rsp_rdata, 32'h0);
    chk({nm, "_bus"}, {27'h0, mem_addr} | {28'h0, mem_wmask} | mem_wdata, 32'h0);
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    bit          done;
    logic [31:0] r;
    string       p;
    p = $sformatf("v%0d", idx);
    @(negedge clk);
    req_valid = 1'b1; req_we = v.we; req_size = v.size; req_unsigned = v.uns;
    req_addr = v.addr; req_wdata = v.wdata;
    chk({p, "_ready"}, 32'(req_ready), 32'h1);
    @(posedge clk);
    done = 1'b0;
    for (int cyc = 1; cyc <= 8 && !done; cyc++) begin
      @(negedge clk);
      chk_bus(p);
      if (cyc == 1) begin
        chk({p, "_c1_busy"}, 32'(req_ready), 32'h0);
        chk({p, "_c1_strb"}, {30'h0, mem_wren, mem_rden}, {30'h0, v.s1});
        chk({p, "_c1_addr"}, {27'h0, mem_addr}, {27'h0, v.a1});
        chk({p, "_c1_mask"}, {28'h0, mem_wmask}, {28'h0, v.m1});
        chk({p, "_c1_wdata"}, mem_wdata, v.w1);
        // Scramble request inputs: the block must use its latched copy.
        r = $urandom; req_valid = 1'b0; req_we = r[0]; req_unsigned = r[1];
        req_size = r[3:2]; req_addr = r[10:4]; req_wdata = $urandom;
      end
      if (cyc == 2 && v.lat >= 2) begin
        chk({p, "_c2_strb"}, {30'h0, mem_wren, mem_rden}, {30'h0, v.s2});
        chk({p, "_c2_addr"}, {27'h0, mem_addr}, {27'h0, v.a2});
        chk({p, "_c2_mask"}, {28'h0, mem_wmask}, {28'h0, v.m2});
        chk({p, "_c2_wdata"}, mem_wdata, v.w2);
      end
      if (rsp_valid) begin
        done = 1'b1;
        chk({p, "_latency"}, 32'(cyc), 32'(v.lat));
        chk({p, "_rdata"}, rsp_rdata, v.rdata);
        chk({p, "_err"}, 32'(rsp_err), 32'(v.err));
      end
    end
    if (!done) chk({p, "_rsp_timeout"}, 32'h0, 32'h1);
    @(negedge clk);
    chk({p, "_pulse_end"}, {30'h0, rsp_valid, rsp_err}, 32'h0);
    chk({p, "_rdata_hold"}, rsp_rdata, v.rdata);
  endtask

  initial begin
    //            we    sz    uns   addr   wdata         lat  s1     a1  m1    w1            s2     a2  m2    w2            rdata         err
    vecs[0]  = mk(1'b1, 2'd2, 1'b0, 7'h08, 32'hDEADBEEF, 2, 2'b10, 2,  4'hF, 32'hDEADBEEF, 2'b00, 0,  4'h0, 32'h0,        32'h0,        1'b0);
    vecs[1]  = mk(1'b1, 2'd2, 1'b0, 7'h0B, 32'h11223344, 3, 2'b10, 2,  4'h8, 32'h44000000, 2'b10, 3,  4'h7, 32'h00112233, 32'h0,        1'b0);
    vecs[2]  = mk(1'b0, 2'd0, 1'b0, 7'h09, 32'h0,        3, 2'b01, 2,  4'h0, 32'h0,        2'b00, 0,  4'h0, 32'h0,        32'hFFFFFFBE, 1'b0);
    vecs[3]  = mk(1'b0, 2'd0, 1'b1, 7'h09, 32'h0,        3, 2'b01, 2,  4'h0, 32'h0,        2'b00, 0,  4'h0, 32'h0,        32'h000000BE, 1'b0);
    vecs[4]  = mk(1'b0, 2'd2, 1'b0, 7'h0A, 32'h0,        4, 2'b01, 2,  4'h0, 32'h0,        2'b01, 3,  4'h0, 32'h0,        32'h223344AD, 1'b0);
    vecs[5]  = mk(1'b0, 2'd1, 1'b0, 7'h0A, 32'h0,        3, 2'b01, 2,  4'h0, 32'h0,        2'b00, 0,  4'h0, 32'h0,        32'h000044AD, 1'b0);
    vecs[6]  = mk(1'b0, 2'd1, 1'b0, 7'h09, 32'h0,        3, 2'b01, 2,  4'h0, 32'h0,        2'b00, 0,  4'h0, 32'h0,        32'hFFFFADBE, 1'b0);
    vecs[7]  = mk(1'b1, 2'd0, 1'b0, 7'h0D, 32'h00000080, 2, 2'b10, 3,  4'h2, 32'h00008000, 2'b00, 0,  4'h0, 32'h0,        32'h0,        1'b0);
    vecs[8]  = mk(1'b0, 2'd0, 1'b0, 7'h0D, 32'h0,        3, 2'b01, 3,  4'h0, 32'h0,        2'b00, 0,  4'h0, 32'h0,        32'hFFFFFF80, 1'b0);
    vecs[9]  = mk(1'b0, 2'd0, 1'b1, 7'h0C, 32'h0,        3, 2'b01, 3,  4'h0, 32'h0,        2'b00, 0,  4'h0, 32'h0,        32'h00000033, 1'b0);
    vecs[10] = mk(1'b1, 2'd1, 1'b0, 7'h7F, 32'h0000A55A, 3, 2'b10, 31, 4'h8, 32'h5A000000, 2'b10, 0,  4'h1, 32'h000000A5, 32'h0,        1'b0);
    vecs[11] = mk(1'b0, 2'd1, 1'b1, 7'h7F, 32'h0,        4, 2'b01, 31, 4'h0, 32'h0,        2'b01, 0,  4'h0, 32'h0,        32'h0000A55A, 1'b0);
    vecs[12] = mk(1'b0, 2'd1, 1'b0, 7'h7F, 32'h0,        4, 2'b01, 31, 4'h0, 32'h0,        2'b01, 0,  4'h0, 32'h0,        32'hFFFFA55A, 1'b0);
    vecs[13] = mk(1'b0, 2'd3, 1'b0, 7'h10, 32'h0,        1, 2'b00, 0,  4'h0, 32'h0,        2'b00, 0,  4'h0, 32'h0,        32'h0,        1'b1);
    vecs[14] = mk(1'b1, 2'd3, 1'b0, 7'h11, 32'hCAFEF00D, 1, 2'b00, 0,  4'h0, 32'h0,        2'b00, 0,  4'h0, 32'h0,        32'h0,        1'b1);
    vecs[15] = mk(1'b1, 2'd2, 1'b0, 7'h14, 32'h01020304, 2, 2'b10, 5,  4'hF, 32'h01020304, 2'b00, 0,  4'h0, 32'h0,        32'h0,        1'b0);

    #1;
    chk_all_zero("reset0");
    repeat (3) @(posedge clk);
    @(negedge clk);
    mem_clear = 1'b0;
    rst_n = 1'b1;
    #1;
    chk("reset0_ready", 32'(req_ready), 32'h1);

    for (int i = 0; i < 16; i++) run_vec(i, vecs[i]);

    // Reset while the second half of a spanning load is on the bus.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_unsigned = 1'b0; req_addr = 7'h0A;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(posedge clk);
    #2;
    chk("rst_pre_ldhi", {26'h0, mem_rden, mem_addr}, {26'h0, 1'b1, 5'd3});
    rst_n = 1'b0;
    #1;
    chk_all_zero("rst_mid");
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk_all_zero("rst_hold");
    end
    rst_n = 1'b1;
    #1;
    chk("rst_rel_ready", 32'(req_ready), 32'h1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("rst_no_rsp", {30'h0, rsp_valid, mem_rden}, 32'h0);
    end
    run_vec(100, vecs[0]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
